// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback, read-port and scoreboard signals of the register file.
// The master side (pipeline) drives requests; the slave side (wb_regfile) returns data and busy.
interface wb_regfile_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic          wwreg;
  logic [AW-1:0] wrn;
  logic [DW-1:0] wdi;

  logic [AW-1:0] rna;
  logic [AW-1:0] rnb;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;

  logic          sb_set;
  logic [AW-1:0] sb_rn;
  logic          busy_a;
  logic          busy_b;

  logic [31:0]   wr_cnt;

  modport master (
    output wwreg, wrn, wdi, rna, rnb, sb_set, sb_rn,
    input  qa, qb, busy_a, busy_b, wr_cnt
  );

  modport slave (
    input  wwreg, wrn, wdi, rna, rnb, sb_set, sb_rn,
    output qa, qb, busy_a, busy_b, wr_cnt
  );

endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: 2**AW x DW register file written by writeback, with a pending-write scoreboard for decode.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and mask busy for the completing register.
module wb_regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic        clk,
  input  logic        clrn,
  wb_regfile_if.slave rf
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] set_vec;
  logic [31:0]      wr_cnt_q;
  logic             wr_commit;
  logic [DW-1:0]    qa_d;
  logic [DW-1:0]    qb_d;
  logic             busy_a_d;
  logic             busy_b_d;

  // Writes to register 0 are dropped entirely, including the commit count.
  assign wr_commit = rf.wwreg && (rf.wrn != '0);

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wr_commit) begin
      clr_vec[rf.wrn] = 1'b1;
    end
    if (rf.sb_set && (rf.sb_rn != '0)) begin
      set_vec[rf.sb_rn] = 1'b1;
    end
  end

  // Set is applied after clear so a newly issued producer outranks the one completing now.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[rf.wrn] <= rf.wdi;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_cnt_q <= '0;
    end else if (wr_commit) begin
      wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_en;

  // Forwarding is held off during reset so outputs stay zero while clrn is low.
  assign fwd_en = clrn && wr_commit;

  always_comb begin
    qa_d     = (rf.rna == '0) ? '0 : regs[rf.rna];
    qb_d     = (rf.rnb == '0) ? '0 : regs[rf.rnb];
    busy_a_d = pending_q[rf.rna];
    busy_b_d = pending_q[rf.rnb];
    if (fwd_en && (rf.rna == rf.wrn)) begin
      qa_d = rf.wdi;
      if (!set_vec[rf.rna]) begin
        busy_a_d = 1'b0;
      end
    end
    if (fwd_en && (rf.rnb == rf.wrn)) begin
      qb_d = rf.wdi;
      if (!set_vec[rf.rnb]) begin
        busy_b_d = 1'b0;
      end
    end
  end
`else
  always_comb begin
    qa_d     = (rf.rna == '0) ? '0 : regs[rf.rna];
    qb_d     = (rf.rnb == '0) ? '0 : regs[rf.rnb];
    busy_a_d = pending_q[rf.rna];
    busy_b_d = pending_q[rf.rnb];
  end
`endif

  assign rf.qa     = qa_d;
  assign rf.qb     = qb_d;
  assign rf.busy_a = busy_a_d;
  assign rf.busy_b = busy_b_d;
  assign rf.wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against an array-based reference model.
// The expected read/busy behaviour follows REGFILE_BYPASS_EN when the bench is built with it.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic clrn;

  wb_regfile_if #(.DW(32), .AW(5)) bus ();

  wb_regfile #(.DW(32), .AW(5)) dut (
    .clk  (clk),
    .clrn (clrn),
    .rf   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] model_regs [32];
  bit          model_pend [32];
  logic [31:0] model_cnt;
  int          tests_run;
  int          tests_failed;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      model_regs[i] = '0;
      model_pend[i] = 1'b0;
    end
    model_cnt = '0;
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] rn, input logic we, input logic [4:0] wn,
                                          input logic [31:0] wd);
    if (!clrn || rn == 5'd0) return 32'd0;
    if (BYPASS && we && wn != 5'd0 && wn == rn) return wd;
    return model_regs[rn];
  endfunction

  function automatic logic expBusy(input logic [4:0] rn, input logic we, input logic [4:0] wn,
                                   input logic ss, input logic [4:0] sr);
    if (!clrn) return 1'b0;
    if (BYPASS && we && wn == rn && !(ss && sr == rn)) return 1'b0;
    return model_pend[rn];
  endfunction

  // Drive one cycle at the falling edge, check outputs before the rising edge, then advance the model.
  task automatic applyStimulus(input logic we, input logic [4:0] wn, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input logic ss, input logic [4:0] sr);
    bus.wwreg  = we;
    bus.wrn    = wn;
    bus.wdi    = wd;
    bus.rna    = ra;
    bus.rnb    = rb;
    bus.sb_set = ss;
    bus.sb_rn  = sr;
    #1;
    checkOutput("qa", bus.qa, expRead(ra, we, wn, wd));
    checkOutput("qb", bus.qb, expRead(rb, we, wn, wd));
    checkOutput("busy_a", {31'd0, bus.busy_a}, {31'd0, expBusy(ra, we, wn, ss, sr)});
    checkOutput("busy_b", {31'd0, bus.busy_b}, {31'd0, expBusy(rb, we, wn, ss, sr)});
    checkOutput("wr_cnt", bus.wr_cnt, clrn ? model_cnt : 32'd0);
    @(posedge clk);
    if (clrn) begin
      if (we && wn != 5'd0) begin
        model_regs[wn] = wd;
        model_cnt      = model_cnt + 32'd1;
      end
      for (int r = 1; r < 32; r++) begin
        if (ss && sr == r[4:0]) model_pend[r] = 1'b1;
        else if (we && wn == r[4:0]) model_pend[r] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    applyStimulus(1'b0, 5'd0, 32'd0, ra, rb, 1'b0, 5'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    modelReset();
    clrn = 1'b0;
    bus.wwreg = 1'b0; bus.wrn = '0; bus.wdi = '0; bus.rna = '0; bus.rnb = '0;
    bus.sb_set = 1'b0; bus.sb_rn = '0;
    @(negedge clk);

    // Activity while held in reset must be invisible and discarded.
    applyStimulus(1'b1, 5'd5, 32'hCAFE0001, 5'd5, 5'd6, 1'b1, 5'd6);
    applyStimulus(1'b1, 5'd6, 32'hCAFE0002, 5'd6, 5'd5, 1'b1, 5'd5);
    clrn = 1'b1;
    idle(5'd5, 5'd6);

    // Register 0 write and pending set are ignored.
    applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 5'd0);
    idle(5'd0, 5'd0);

    // Basic write and read on both ports.
    applyStimulus(1'b1, 5'd5, 32'h12345678, 5'd1, 5'd2, 1'b0, 5'd0);
    idle(5'd5, 5'd5);

    // Same-cycle read of the register being written.
    applyStimulus(1'b1, 5'd7, 32'h00000001, 5'd0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5, 1'b0, 5'd0);
    idle(5'd7, 5'd7);

    // Scoreboard lifecycle, including set-wins on a coincident clear.
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9);
    idle(5'd9, 5'd9);
    applyStimulus(1'b1, 5'd9, 32'h00000909, 5'd9, 5'd9, 1'b0, 5'd0);
    idle(5'd9, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd1, 1'b1, 5'd9);
    applyStimulus(1'b1, 5'd9, 32'h00000999, 5'd9, 5'd9, 1'b1, 5'd9);
    idle(5'd9, 5'd9);
    applyStimulus(1'b1, 5'd9, 32'h00009999, 5'd9, 5'd9, 1'b1, 5'd10);
    idle(5'd9, 5'd10);

    // Commit counter wraps to zero.
    force dut.wr_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.wr_cnt_q;
    model_cnt = 32'hFFFFFFFF;
    @(negedge clk);
    applyStimulus(1'b1, 5'd3, 32'h33333333, 5'd3, 5'd0, 1'b0, 5'd0);
    idle(5'd3, 5'd0);

    // Randomized traffic concentrated on a few registers to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wn, ra, rb, sr;
      logic       narrow;
      narrow = ($urandom_range(0, 3) != 0);
      wn = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ra = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 4) == 0) ? ra : 5'($urandom_range(0, 7));
      sr = ($urandom_range(0, 2) == 0) ? wn : 5'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), wn, $urandom, ra, rb, 1'($urandom_range(0, 1)), sr);
    end

    // Asynchronous reset between edges with r4 written and pending.
    applyStimulus(1'b1, 5'd4, 32'h00000055, 5'd4, 5'd4, 1'b1, 5'd4);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b0, 5'd0);
    bus.wwreg = 1'b0; bus.sb_set = 1'b0; bus.rna = 5'd4; bus.rnb = 5'd4;
    #2;
    checkOutput("pre_reset_qa", bus.qa, model_regs[4]);
    checkOutput("pre_reset_busy", {31'd0, bus.busy_a}, {31'd0, model_pend[4]});
    clrn = 1'b0;
    #1;
    checkOutput("async_reset_qa", bus.qa, 32'd0);
    checkOutput("async_reset_busy", {31'd0, bus.busy_a}, 32'd0);
    checkOutput("async_reset_cnt", bus.wr_cnt, 32'd0);
    modelReset();
    @(negedge clk);
    clrn = 1'b1;
    idle(5'd4, 5'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
